// File: rtl/scm65_if.sv
// scm65_if: bundle of the scm65 data/address/enable signals.
// Signals: DIN, RADDR, RE, WADDR, WE (driven by master), DOUT (driven by slave).
// Clock and reset remain plain ports on the memory.
interface scm65_if #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] DIN;
  logic [DATA_WIDTH-1:0] DOUT;
  logic [ADDR_WIDTH-1:0] RADDR;
  logic                  RE;
  logic [ADDR_WIDTH-1:0] WADDR;
  logic                  WE;

  modport master (
    output DIN,
    output RADDR,
    output RE,
    output WADDR,
    output WE,
    input  DOUT
  );

  modport slave (
    input  DIN,
    input  RADDR,
    input  RE,
    input  WADDR,
    input  WE,
    output DOUT
  );
endinterface

// File: rtl/scm65.sv
// scm65: DEPTH x DATA_WIDTH register-file memory, one write port and one
// registered read port (latency 1), read-before-write on address collision.
// Ports (positional order is fixed for existing instantiations):
//   clk   - rising-edge clock
//   DIN   - write data
//   DOUT  - registered read data
//   RADDR - read address; out-of-range reads return zero
//   RE    - read enable; DOUT holds when low
//   WADDR - write address; out-of-range writes are dropped
//   WE    - write enable
//   rst_n - asynchronous active-low reset, clears storage and DOUT
module scm65 #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 65
) (
  input  logic                  clk,
  input  logic [DATA_WIDTH-1:0] DIN,
  output logic [DATA_WIDTH-1:0] DOUT,
  input  logic [ADDR_WIDTH-1:0] RADDR,
  input  logic                  RE,
  input  logic [ADDR_WIDTH-1:0] WADDR,
  input  logic                  WE,
  input  logic                  rst_n
);

  localparam int unsigned CMP_W = 32;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  wr_ok;
  logic                  rd_ok;

  // Address range qualification, widened so the compare is width-matched.
  assign wr_ok = (CMP_W'(WADDR) < DEPTH);
  assign rd_ok = (CMP_W'(RADDR) < DEPTH);

  // Storage: the read below samples the pre-edge word, giving read-before-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (WE && wr_ok) begin
      mem[WADDR] <= DIN;
    end
  end

  // Registered read port; out-of-range reads load zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      DOUT <= '0;
    end else if (RE) begin
      DOUT <= rd_ok ? mem[RADDR] : '0;
    end
  end

endmodule

// File: tb/tb_scm65.sv
// tb_scm65: directed self-checking bench for scm65.
module tb_scm65;
  localparam int unsigned AW    = 7;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 65;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  scm65_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  scm65 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .DIN   (bus.DIN),
    .DOUT  (bus.DOUT),
    .RADDR (bus.RADDR),
    .RE    (bus.RE),
    .WADDR (bus.WADDR),
    .WE    (bus.WE),
    .rst_n (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "timeout");
  end

  // One rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.WE    = 1'b0;
    bus.RE    = 1'b0;
    bus.WADDR = '0;
    bus.RADDR = '0;
    bus.DIN   = '0;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    bus.WE    = 1'b1;
    bus.WADDR = AW'(a);
    bus.DIN   = d;
    bus.RE    = 1'b0;
    step();
    bus.WE    = 1'b0;
  endtask

  task automatic rd(input int a);
    bus.WE    = 1'b0;
    bus.RE    = 1'b1;
    bus.RADDR = AW'(a);
    step();
    bus.RE    = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #3;
    total++;
    if (bus.DOUT !== 32'h0) begin
      bad++;
      $display("FAIL reset_dout: got=%h exp=%h", bus.DOUT, 32'h0);
    end
    step();
    step();
    #2 rst_n = 1'b1;
    rd(5);
    total++;
    if (bus.DOUT !== 32'h0) begin
      bad++;
      $display("FAIL reset_read5: got=%h exp=%h", bus.DOUT, 32'h0);
    end
  endtask

  task automatic test_write_read();
    wr(3, 32'hDEADBEEF);
    total++;
    if (bus.DOUT !== 32'h0) begin
      bad++;
      $display("FAIL write_no_dout_change: got=%h exp=%h", bus.DOUT, 32'h0);
    end
    rd(3);
    total++;
    if (bus.DOUT !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL read3: got=%h exp=%h", bus.DOUT, 32'hDEADBEEF);
    end
    bus.RADDR = AW'(0);
    step();
    step();
    total++;
    if (bus.DOUT !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL hold_re0: got=%h exp=%h", bus.DOUT, 32'hDEADBEEF);
    end
  endtask

  task automatic test_read_before_write();
    wr(7, 32'h11111111);
    bus.WE    = 1'b1;
    bus.WADDR = AW'(7);
    bus.DIN   = 32'h22222222;
    bus.RE    = 1'b1;
    bus.RADDR = AW'(7);
    step();
    idle();
    total++;
    if (bus.DOUT !== 32'h11111111) begin
      bad++;
      $display("FAIL rbw_old: got=%h exp=%h", bus.DOUT, 32'h11111111);
    end
    rd(7);
    total++;
    if (bus.DOUT !== 32'h22222222) begin
      bad++;
      $display("FAIL rbw_new: got=%h exp=%h", bus.DOUT, 32'h22222222);
    end
  endtask

  task automatic test_back_to_back();
    wr(10, 32'hAAAA0010);
    bus.WE    = 1'b1;
    bus.WADDR = AW'(11);
    bus.DIN   = 32'hBBBB0011;
    bus.RE    = 1'b1;
    bus.RADDR = AW'(10);
    step();
    idle();
    total++;
    if (bus.DOUT !== 32'hAAAA0010) begin
      bad++;
      $display("FAIL simul_read10: got=%h exp=%h", bus.DOUT, 32'hAAAA0010);
    end
    rd(11);
    total++;
    if (bus.DOUT !== 32'hBBBB0011) begin
      bad++;
      $display("FAIL simul_write11: got=%h exp=%h", bus.DOUT, 32'hBBBB0011);
    end
    rd(12);
    total++;
    if (bus.DOUT !== 32'h0) begin
      bad++;
      $display("FAIL neighbour12: got=%h exp=%h", bus.DOUT, 32'h0);
    end
    rd(10);
    total++;
    if (bus.DOUT !== 32'hAAAA0010) begin
      bad++;
      $display("FAIL reread10: got=%h exp=%h", bus.DOUT, 32'hAAAA0010);
    end
  endtask

  task automatic test_boundaries();
    wr(0, 32'hA5A5A5A5);
    wr(64, 32'h5A5A5A5A);
    rd(0);
    total++;
    if (bus.DOUT !== 32'hA5A5A5A5) begin
      bad++;
      $display("FAIL bound_read0: got=%h exp=%h", bus.DOUT, 32'hA5A5A5A5);
    end
    rd(64);
    total++;
    if (bus.DOUT !== 32'h5A5A5A5A) begin
      bad++;
      $display("FAIL bound_read64: got=%h exp=%h", bus.DOUT, 32'h5A5A5A5A);
    end
    wr(65, 32'hFFFFFFFF);
    rd(65);
    total++;
    if (bus.DOUT !== 32'h0) begin
      bad++;
      $display("FAIL bound_read65: got=%h exp=%h", bus.DOUT, 32'h0);
    end
    rd(64);
    total++;
    if (bus.DOUT !== 32'h5A5A5A5A) begin
      bad++;
      $display("FAIL bound_64_after65: got=%h exp=%h", bus.DOUT, 32'h5A5A5A5A);
    end
    rd(0);
    total++;
    if (bus.DOUT !== 32'hA5A5A5A5) begin
      bad++;
      $display("FAIL bound_0_after65: got=%h exp=%h", bus.DOUT, 32'hA5A5A5A5);
    end
    rd(63);
    total++;
    if (bus.DOUT !== 32'h0) begin
      bad++;
      $display("FAIL bound_read63: got=%h exp=%h", bus.DOUT, 32'h0);
    end
    wr(127, 32'hFFFFFFFF);
    rd(1);
    total++;
    if (bus.DOUT !== 32'h0) begin
      bad++;
      $display("FAIL bound_1_after127: got=%h exp=%h", bus.DOUT, 32'h0);
    end
    rd(3);
    rd(127);
    total++;
    if (bus.DOUT !== 32'h0) begin
      bad++;
      $display("FAIL bound_read127: got=%h exp=%h", bus.DOUT, 32'h0);
    end
  endtask

  task automatic test_reset_mid();
    int addrs [4];
    addrs = '{0, 1, 32, 64};
    for (int k = 0; k < int'(DEPTH); k++) begin
      wr(k, DW'(k));
    end
    rd(64);
    total++;
    if (bus.DOUT !== 32'd64) begin
      bad++;
      $display("FAIL fill_read64: got=%h exp=%h", bus.DOUT, 32'd64);
    end
    rd(33);
    total++;
    if (bus.DOUT !== 32'd33) begin
      bad++;
      $display("FAIL fill_read33: got=%h exp=%h", bus.DOUT, 32'd33);
    end
    // Assert reset between edges with a write and read pending.
    bus.WE    = 1'b1;
    bus.WADDR = AW'(2);
    bus.DIN   = 32'hCAFEF00D;
    bus.RE    = 1'b1;
    bus.RADDR = AW'(33);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (bus.DOUT !== 32'h0) begin
      bad++;
      $display("FAIL midreset_dout_now: got=%h exp=%h", bus.DOUT, 32'h0);
    end
    step();
    total++;
    if (bus.DOUT !== 32'h0) begin
      bad++;
      $display("FAIL midreset_re_ignored: got=%h exp=%h", bus.DOUT, 32'h0);
    end
    idle();
    #3 rst_n = 1'b1;
    // First edge after release performs a normal write and read together.
    bus.WE    = 1'b1;
    bus.WADDR = AW'(20);
    bus.DIN   = 32'h00001234;
    bus.RE    = 1'b1;
    bus.RADDR = AW'(64);
    step();
    idle();
    total++;
    if (bus.DOUT !== 32'h0) begin
      bad++;
      $display("FAIL post_reset_read64: got=%h exp=%h", bus.DOUT, 32'h0);
    end
    rd(20);
    total++;
    if (bus.DOUT !== 32'h00001234) begin
      bad++;
      $display("FAIL post_reset_write20: got=%h exp=%h", bus.DOUT, 32'h00001234);
    end
    foreach (addrs[j]) begin
      rd(addrs[j]);
      total++;
      if (bus.DOUT !== 32'h0) begin
        bad++;
        $display("FAIL post_reset_clear addr=%0d: got=%h exp=%h", addrs[j], bus.DOUT, 32'h0);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    idle();
    test_reset();
    test_write_read();
    test_read_before_write();
    test_back_to_back();
    test_boundaries();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
